vga_scan_gen: RTL and testbench
===============================

# vga_scan_gen

VGA 640x480@60 Hz raster timing generator and pixel output stage. It divides the system clock to a pixel tick, runs the horizontal and vertical counters, and publishes the current visible coordinate on `scan_x`/`scan_y` to every shape/text drawing block. It samples the combined colour those blocks return and drives the blanked, registered RGB and sync pins to the connector.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; a 100 MHz clock gives a 25 MHz pixel rate. Legal range is 2..16.
- `H_VIS`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing, in pixels.
- `V_VIS`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing, in lines.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `pixel_rgb`, in, 12: colour from the drawing logic for the current `scan_x`/`scan_y`, ordered {R[3:0],G[3:0],B[3:0]}.
- `scan_x`, out, 10: visible column 0..639. It reads 0 outside active video.
- `scan_y`, out, 9: visible row 0..479. It reads 0 outside active video.
- `active`, out, 1: the current counter position is inside the visible area.
- `pix_en`, out, 1: one-`clk` pixel tick.
- `frame_start`, out, 1: one-`clk` pulse on the `pix_en` where the counters reach (0,0).
- `hsync`, out, 1: horizontal sync, active-low.
- `vsync`, out, 1: vertical sync, active-low.
- `vga_r`, `vga_g`, `vga_b`, out, 4 each: registered colour outputs.

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. `pix_en` is 1 while `div == CLK_DIV-1`.
- `h_cnt` is 10 bits and counts 0..799. It advances only on `pix_en`.
- `v_cnt` is 10 bits and counts 0..524. It advances on `pix_en` when `h_cnt` wraps 799→0. It wraps 524→0.
- `active` = (`h_cnt` < 640) && (`v_cnt` < 480). This decode is combinational from the counters.
  - `scan_x` = `h_cnt[9:0]` while active, else 0.
  - `scan_y` = `v_cnt[8:0]` while active, else 0.
- Sync decodes are taken from the counters.
  - The hsync region is `h_cnt` in 656..751.
  - The vsync region is `v_cnt` in 490..491.
  - Both are asserted low.
- Output stage, updated only on `pix_en`:
  - `vga_*` ← `active ? pixel_rgb : 0`.
  - `hsync`/`vsync` ← decodes of the same counter position.
- `pixel_rgb` must be stable by the `clk` edge where `pix_en` = 1. Drawing blocks are combinational; they have CLK_DIV-1 cycles of slack.
- `frame_start` = `pix_en` && `h_cnt` == 799 && `v_cnt` == 524. It is therefore registered into the pulse coincident with the counters going to (0,0).

## Timing
- Reset (`rst_n` = 0 at a `clk` edge) sets:
  - `div`, `h_cnt`, `v_cnt` = 0.
  - `hsync` = `vsync` = 1.
  - `vga_*` = 0.
  - `frame_start` = 0.
  - As a consequence, `active` = 1 and `scan_x` = `scan_y` = 0 during reset.
- Reset has priority over every other update. Asserting it mid-frame restarts at (0,0) on the next edge with no partial-line residue.
- First `pix_en` falls in cycle CLK_DIV-1 after reset release.
- Latency: `hsync`/`vsync`/`vga_*` lag `scan_x`/`scan_y` by exactly one pixel period (CLK_DIV clks). The three are mutually aligned.
- Line period is 800 × CLK_DIV clks (3200 at the default). Frame period is 525 lines = 1 680 000 clks.
- `pix_en` and `frame_start` are high for exactly one `clk` each.

## Configuration
- `VGA_BORDER_EN` defined:
  - The output stage forces 12'hFFF for a 1-pixel white border, overriding `pixel_rgb`.
  - The border is active pixels with `scan_x` ∈ {0,639} or `scan_y` ∈ {0,479}.
- `VGA_BORDER_EN` undefined: `pixel_rgb` passes unmodified.
- Sync timing and latency are identical in both builds.

## Test plan
- **Reset values.** Hold `rst_n` = 0 for 5 clks. Required: `hsync` = `vsync` = 1, `vga_*` = 0, `scan_x` = `scan_y` = 0, `frame_start` = 0. After release, first `pix_en` at clk 3 (CLK_DIV = 4).
- **Horizontal timing.** Free-run one line. Required:
  - Consecutive `hsync` falling edges are 3200 clks apart.
  - `hsync` low for 384 clks.
  - `hsync` falls 656 pixels (+1 pixel latency) after `scan_x` = 0.
  - `active` high for 640 pixels per line.
- **Vertical/frame timing.** Free-run 2 frames. Required:
  - `frame_start` pulses 1 680 000 clks apart.
  - `vsync` low for 1600 pixels (6400 clks) starting on line 490.
  - `scan_y` sweeps 0..479, then stays 0 for 45 lines.
- **Colour blanking.** Drive `pixel_rgb` = 12'hA5C constantly. Required:
  - `vga_*` = A/5/C on pixels one period after `active` = 1.
  - `vga_*` = 0 for all blanking pixels, including (640,0) and (0,480).
- **Reset mid-operation.** Pulse `rst_n` low for 1 clk at `h_cnt` = 300, `v_cnt` = 200. Required: counters at (0,0) next edge; the next `frame_start` arrives 1 680 000 clks later.
- **Border build.** With `VGA_BORDER_EN` and `pixel_rgb` = 12'h000, `vga_*` = F/F/F only at (0,y), (639,y), (x,0), (x,479), and 0 elsewhere. Without the macro, all pixels are 0.

Source files
------------

// File: rtl/vga_scan_gen.sv
// vga_scan_gen
//   VGA raster timing generator and pixel output stage (640x480@60 Hz by
//   default). Divides clk down to a pixel tick, runs the horizontal and
//   vertical counters, publishes the visible coordinate to the drawing
//   logic, and registers the blanked colour and sync pins for the connector.
//
//   Build option: define VGA_BORDER_EN to force a 1-pixel white border
//   (12'hFFF) around the visible area, overriding pixel_rgb there.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   pixel_rgb    in   {R,G,B} 4 bits each for the current scan_x/scan_y
//   scan_x       out  visible column, 0 outside active video
//   scan_y       out  visible row, 0 outside active video
//   active       out  counters are inside the visible area
//   pix_en       out  one-clk pixel tick
//   frame_start  out  one-clk pulse as the counters return to (0,0)
//   hsync/vsync  out  active-low syncs, registered
//   vga_r/g/b    out  registered, blanked colour
module vga_scan_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pixel_rgb,
    output logic [9:0]  scan_x,
    output logic [8:0]  scan_y,
    output logic        active,
    output logic        pix_en,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);

    logic [3:0]  r_div;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_frame_start;
    logic [11:0] r_rgb;

    logic        w_pix_en;
    logic        w_active;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_hs_region;
    logic        w_vs_region;
    logic [11:0] w_rgb_next;

    assign w_pix_en    = (r_div == DIV_LAST);
    assign w_h_wrap    = (r_h_cnt == H_LAST);
    assign w_v_wrap    = (r_v_cnt == V_LAST);
    assign w_active    = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
    assign w_hs_region = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
    assign w_vs_region = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);

`ifdef VGA_BORDER_EN
    localparam logic [9:0] H_VIS_LAST = 10'(H_VIS - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);

    logic w_border;

    // Border only matters inside the visible area; blanking still wins.
    assign w_border   = (r_h_cnt == '0) || (r_h_cnt == H_VIS_LAST) ||
                        (r_v_cnt == '0) || (r_v_cnt == V_VIS_LAST);
    assign w_rgb_next = !w_active ? '0 : (w_border ? '1 : pixel_rgb);
`else
    assign w_rgb_next = w_active ? pixel_rgb : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
            r_rgb         <= '0;
        end else begin
            // Registered so the pulse lines up with the counters at (0,0).
            r_frame_start <= w_pix_en && w_h_wrap && w_v_wrap;
            if (w_pix_en) begin
                r_div   <= '0;
                // Output stage samples the position being left, so colour
                // and syncs trail scan_x/scan_y by exactly one pixel.
                r_rgb   <= w_rgb_next;
                r_hsync <= ~w_hs_region;
                r_vsync <= ~w_vs_region;
                if (w_h_wrap) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end else begin
                r_div <= r_div + 4'd1;
            end
        end
    end

    assign pix_en      = w_pix_en;
    assign active      = w_active;
    assign scan_x      = w_active ? r_h_cnt : '0;
    assign scan_y      = w_active ? r_v_cnt[8:0] : '0;
    assign frame_start = r_frame_start;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen
//   Scoreboard bench for vga_scan_gen. A reduced-geometry instance is
//   checked pixel by pixel against an arithmetic raster model over several
//   frames (constant, black and random colour phases, plus a mid-frame
//   reset). A default-geometry instance is checked for line-level timing.
module tb_vga_scan_gen;

    localparam int unsigned CD    = 4;
    localparam int unsigned HV    = 16;
    localparam int unsigned HF    = 4;
    localparam int unsigned HS    = 6;
    localparam int unsigned HB    = 6;
    localparam int unsigned VV    = 8;
    localparam int unsigned VF    = 2;
    localparam int unsigned VS    = 2;
    localparam int unsigned VB    = 3;
    localparam int unsigned HT    = HV + HF + HS + HB;
    localparam int unsigned VT    = VV + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;
    localparam int unsigned RUN   = 5 * FRAME * CD;

    typedef struct {
        int unsigned start;
        int unsigned due;
        bit          fs;
        logic [9:0]  sx;
        logic [8:0]  sy;
        bit          act;
        logic [11:0] rgb;
        bit          hs;
        bit          vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_n_def;
    logic [11:0] pixel_rgb;
    logic [9:0]  scan_x;
    logic [8:0]  scan_y;
    logic        active, pix_en, frame_start, hsync, vsync;
    logic [3:0]  vga_r, vga_g, vga_b;

    logic [11:0] d_rgb_in;
    logic [9:0]  d_scan_x;
    logic [8:0]  d_scan_y;
    logic        d_active, d_pix_en, d_frame_start, d_hsync, d_vsync;
    logic [3:0]  d_r, d_g, d_b;

    int          checks   = 0;
    int          failures = 0;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned gp = 0;
    logic [11:0] prev_rgb = '0;
    bit          chk_reset = 0;
    bit          running = 0;
    bit          mid_done = 0;

    always #5 clk = ~clk;

    vga_scan_gen #(
        .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .pixel_rgb(pixel_rgb),
        .scan_x(scan_x), .scan_y(scan_y), .active(active), .pix_en(pix_en),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    vga_scan_gen u_dut_def (
        .clk(clk), .rst_n(rst_n_def), .pixel_rgb(d_rgb_in),
        .scan_x(d_scan_x), .scan_y(d_scan_y), .active(d_active), .pix_en(d_pix_en),
        .frame_start(d_frame_start), .hsync(d_hsync), .vsync(d_vsync),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raster model: pixel n since reset maps to (n mod HT, n div HT mod VT);
    // outputs seen during pixel n describe pixel n-1.
    function automatic exp_t model(input int unsigned n, input logic [11:0] prev);
        exp_t        e;
        int unsigned h, v, ph, pv;
        bit          pact;
        h      = n % HT;
        v      = (n / HT) % VT;
        e.act  = (h < HV) && (v < VV);
        e.sx   = e.act ? 10'(h) : '0;
        e.sy   = e.act ? 9'(v) : '0;
        e.fs   = (n != 0) && (n % FRAME == 0);
        e.start = 0;
        e.due   = 0;
        if (n == 0) begin
            e.rgb = '0;
            e.hs  = 1'b1;
            e.vs  = 1'b1;
        end else begin
            ph   = (n - 1) % HT;
            pv   = ((n - 1) / HT) % VT;
            pact = (ph < HV) && (pv < VV);
            e.hs = !((ph >= HV + HF) && (ph < HV + HF + HS));
            e.vs = !((pv >= VV + VF) && (pv < VV + VF + VS));
`ifdef VGA_BORDER_EN
            if (!pact)
                e.rgb = '0;
            else if ((ph == 0) || (ph == HV - 1) || (pv == 0) || (pv == VV - 1))
                e.rgb = 12'hFFF;
            else
                e.rgb = prev;
`else
            e.rgb = pact ? prev : '0;
`endif
        end
        return e;
    endfunction

    task automatic start_pixel();
        exp_t        e;
        logic [11:0] rgb;
        if (gp < FRAME)          rgb = 12'hA5C;
        else if (gp < 2 * FRAME) rgb = 12'h000;
        else                     rgb = 12'($urandom_range(0, 4095));
        pixel_rgb = rgb;
        e         = model(cyc / CD, prev_rgb);
        e.start   = cyc;
        e.due     = cyc + CD - 1;
        q.push_back(e);
        prev_rgb  = rgb;
        gp++;
    endtask

    // Driver: runs on posedge+1, owns reset and the cycle index since reset.
    initial begin
        rst_n     = 1'b0;
        rst_n_def = 1'b0;
        pixel_rgb = '0;
        d_rgb_in  = 12'hA5C;
        @(posedge clk); #1;
        chk_reset = 1;
        repeat (4) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rst_n_def = 1'b1;
        chk_reset = 0;
        running   = 1;
        cyc       = 0;
        start_pixel();
        for (int k = 0; k < RUN; k++) begin
            bit          was_rst;
            int unsigned n;
            was_rst = !rst_n;
            @(posedge clk); #1;
            if (was_rst) begin
                rst_n = 1'b1;
                cyc   = 0;
            end else begin
                cyc++;
            end
            if (cyc % CD == 0) begin
                n = cyc / CD;
                if (!mid_done && n >= 2 * FRAME && (n % HT) == 5 && ((n / HT) % VT) == 4) begin
                    rst_n    = 1'b0;
                    mid_done = 1;
                    q.delete();
                end else begin
                    start_pixel();
                end
            end
        end
        running = 0;
        @(posedge clk); #1;
        chk("mid_reset_done", 32'(mid_done), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Scoreboard monitor for the reduced instance.
    always @(negedge clk) begin
        exp_t h;
        bit   ep, ef;
        ep = 0;
        ef = 0;
        if (chk_reset) begin
            chk("rst_hsync", 32'(hsync), 1);
            chk("rst_vsync", 32'(vsync), 1);
            chk("rst_vga", 32'({vga_r, vga_g, vga_b}), 0);
            chk("rst_scan_x", 32'(scan_x), 0);
            chk("rst_scan_y", 32'(scan_y), 0);
            chk("rst_active", 32'(active), 1);
            chk("rst_frame_start", 32'(frame_start), 0);
            chk("rst_pix_en", 32'(pix_en), 0);
        end else if (running) begin
            if (q.size() != 0) begin
                h  = q[0];
                ep = (h.due == cyc);
                ef = (h.start == cyc) && h.fs;
            end
            chk("pix_en", 32'(pix_en), 32'(ep));
            chk("frame_start", 32'(frame_start), 32'(ef));
            if (ep) begin
                void'(q.pop_front());
                chk("scan_x", 32'(scan_x), 32'(h.sx));
                chk("scan_y", 32'(scan_y), 32'(h.sy));
                chk("active", 32'(active), 32'(h.act));
                chk("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'(h.rgb));
                chk("hsync", 32'(hsync), 32'(h.hs));
                chk("vsync", 32'(vsync), 32'(h.vs));
            end
        end
    end

    // Interval measurements on the reduced instance.
    int unsigned t_abs = 0, last_hf = 0, last_fs = 0, hs_low = 0, vs_low = 0;
    bit          hf_valid = 0, fs_valid = 0;
    logic        hs_d = 1'b1, vs_d = 1'b1;

    always @(negedge clk) begin
        t_abs++;
        if (!rst_n) begin
            hf_valid = 0;
            hs_low   = 0;
            vs_low   = 0;
            hs_d     = 1'b1;
            vs_d     = 1'b1;
            last_fs  = t_abs + 1;
            fs_valid = 1;
        end else if (running) begin
            if (hs_d && !hsync) begin
                if (hf_valid) chk("hsync_period", t_abs - last_hf, HT * CD);
                last_hf  = t_abs;
                hf_valid = 1;
            end
            if (!hsync) hs_low++;
            else begin
                if (!hs_d) chk("hsync_width", hs_low, HS * CD);
                hs_low = 0;
            end
            if (!vsync) vs_low++;
            else begin
                if (!vs_d) chk("vsync_width", vs_low, VS * HT * CD);
                vs_low = 0;
            end
            if (frame_start) begin
                if (fs_valid) chk("frame_period", t_abs - last_fs, FRAME * CD);
                last_fs  = t_abs;
                fs_valid = 1;
            end
            hs_d = hsync;
            vs_d = vsync;
        end
    end

    // Default 640x480 instance: first tick, line timing and blanking.
    int unsigned dc = 0, d_last_hf = 0, d_hs_low = 0, d_act = 0;
    bit          d_first = 0, d_hf_valid = 0;
    logic        d_hs_d = 1'b1;

    always @(negedge clk) begin
        if (!rst_n_def) begin
            dc         = 0;
            d_first    = 0;
            d_hf_valid = 0;
            d_hs_low   = 0;
            d_act      = 0;
            d_hs_d     = 1'b1;
        end else if (running) begin
            if (d_pix_en && !d_first) begin
                chk("def_first_pix_en", dc, 3);
                d_first = 1;
            end
            if (dc == 3)       chk("def_vga_reset_px", 32'({d_r, d_g, d_b}), 0);
            if (dc == 4)       chk("def_vga_x0", 32'({d_r, d_g, d_b}), 32'h0A5C);
            if (dc == 640 * 4) chk("def_vga_x639", 32'({d_r, d_g, d_b}), 32'h0A5C);
            if (dc == 641 * 4) chk("def_vga_x640_blank", 32'({d_r, d_g, d_b}), 0);
            if (d_pix_en && d_active) d_act++;
            if (d_hs_d && !d_hsync) begin
                if (!d_hf_valid) chk("def_hsync_first_fall", dc, 657 * 4);
                else             chk("def_hsync_period", dc - d_last_hf, 3200);
                chk("def_active_per_line", d_act, 640);
                d_act      = 0;
                d_last_hf  = dc;
                d_hf_valid = 1;
            end
            if (!d_hsync) d_hs_low++;
            else begin
                if (!d_hs_d) chk("def_hsync_width", d_hs_low, 384);
                d_hs_low = 0;
            end
            d_hs_d = d_hsync;
            dc++;
        end
    end

endmodule
